// File: rtl/eth_rx_mem_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_mem_writer_if
// Brief    : Config, byte-stream, PicoRV32 native memory and status bundle
//            for the Ethernet RX memory writer.
// Revision : 1.0
// ============================================================================
interface eth_rx_mem_writer_if #(
    parameter int LEN_W  = 16,
    parameter int ADDR_W = 32
) ();
    logic              cfg_start;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [LEN_W-1:0]  cfg_max_len;

    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;

    logic              mem_valid;
    logic              mem_instr;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;

    logic              done;
    logic [LEN_W-1:0]  byte_count;
    logic              overflow;

    // Writer side: consumes config and stream, initiates memory writes.
    modport master (
        input  cfg_start, cfg_base_addr, cfg_max_len,
        input  s_data, s_valid, s_last,
        input  mem_ready, mem_rdata,
        output s_ready,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output done, byte_count, overflow
    );

    // Environment side: CPU config, RX source and memory responder.
    modport slave (
        output cfg_start, cfg_base_addr, cfg_max_len,
        output s_data, s_valid, s_last,
        output mem_ready, mem_rdata,
        input  s_ready,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  done, byte_count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/eth_rx_mem_writer.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_mem_writer
// Brief    : Packs an RX byte stream big-endian into 32-bit words and writes
//            them to memory over the PicoRV32 native bus. Define
//            ETH_RX_BYTE_STRB_EN for exact strobes on a final partial word.
// Revision : 1.0
// ============================================================================
module eth_rx_mem_writer #(
    parameter int LEN_W  = 16,
    parameter int ADDR_W = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    eth_rx_mem_writer_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_GAP     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_max_len;
    logic [LEN_W-1:0]  r_byte_count;
    logic              r_overflow;
    logic [1:0]        r_lane;
    logic [31:0]       r_buf;
    logic              r_last;

    logic              w_accept;
    logic              w_store;
    logic              w_drop;
    logic              w_s_ready;
    logic              w_mem_valid;
    logic              w_done;
    logic [3:0]        w_wstrb;
    logic              w_unused;

    assign w_accept = (r_state == ST_COLLECT) && bus.s_valid;
    assign w_store  = w_accept && (r_byte_count != r_max_len);
    assign w_drop   = w_accept && (r_byte_count == r_max_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_s_ready   = 1'b0;
        w_mem_valid = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cfg_start) begin
                    w_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                w_s_ready = 1'b1;
                // r_lane == 0 means the buffer is empty while collecting.
                if (w_store && (r_lane == 2'd3)) begin
                    w_next = ST_WRITE;
                end else if (w_accept && bus.s_last) begin
                    w_next = (w_store || (r_lane != 2'd0)) ? ST_WRITE : ST_DONE;
                end
            end
            ST_WRITE: begin
                w_mem_valid = 1'b1;
                if (bus.mem_ready) begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                w_next = r_last ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

`ifdef ETH_RX_BYTE_STRB_EN
    // In WRITE, r_lane counts filled lanes modulo 4; zero means a full word.
    always_comb begin
        case (r_lane)
            2'd1:    w_wstrb = 4'h8;
            2'd2:    w_wstrb = 4'hC;
            2'd3:    w_wstrb = 4'hE;
            default: w_wstrb = 4'hF;
        endcase
    end
`else
    assign w_wstrb = 4'hF;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_max_len    <= '0;
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
            r_lane       <= 2'd0;
            r_buf        <= 32'd0;
            r_last       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cfg_start) begin
                        r_addr       <= {bus.cfg_base_addr[ADDR_W-1:2], 2'b00};
                        r_max_len    <= bus.cfg_max_len;
                        r_byte_count <= '0;
                        r_overflow   <= 1'b0;
                        r_lane       <= 2'd0;
                        r_buf        <= 32'd0;
                        r_last       <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (w_store) begin
                        case (r_lane)
                            2'd0:    r_buf[31:24] <= bus.s_data;
                            2'd1:    r_buf[23:16] <= bus.s_data;
                            2'd2:    r_buf[15:8]  <= bus.s_data;
                            default: r_buf[7:0]   <= bus.s_data;
                        endcase
                        r_lane       <= r_lane + 2'd1;
                        r_byte_count <= r_byte_count + LEN_W'(1);
                    end
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_accept && bus.s_last) begin
                        r_last <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_ready) begin
                        r_addr <= r_addr + ADDR_W'(4);
                    end
                end
                ST_GAP: begin
                    r_buf  <= 32'd0;
                    r_lane <= 2'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.s_ready    = w_s_ready;
    assign bus.mem_valid  = w_mem_valid;
    assign bus.mem_instr  = 1'b0;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_buf;
    assign bus.mem_wstrb  = w_mem_valid ? w_wstrb : 4'h0;
    assign bus.done       = w_done;
    assign bus.byte_count = r_byte_count;
    assign bus.overflow   = r_overflow;

    assign w_unused = ^{bus.mem_rdata, bus.cfg_base_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_mem_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_mem_writer
// Brief    : Randomized scoreboard bench for eth_rx_mem_writer with a frame-
//            level reference model and a decoupled responder/monitor.
// Revision : 1.0
// ============================================================================
module tb_eth_rx_mem_writer;
    localparam int LEN_W  = 16;
    localparam int ADDR_W = 32;

    typedef logic [7:0] u8;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
    typedef struct { int cnt; bit ovf; } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_rx_mem_writer_if #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus ();

    eth_rx_mem_writer #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int  total = 0;
    int  bad = 0;
    int  ready_delay = 2;
    int  n_writes = 0;
    wr_t exp_wr[$];
    res_t exp_res[$];
    u8   frame_q[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: truncate to max_len, split into words, pad.
    task automatic model_frame(input logic [31:0] base, input int maxl);
        int    stored;
        wr_t   w;
        res_t  r;
        logic [31:0] a;
        stored = (frame_q.size() > maxl) ? maxl : frame_q.size();
        a = {base[31:2], 2'b00};
        for (int wi = 0; wi * 4 < stored; wi++) begin
            w.addr = a;
            w.data = 32'd0;
            w.strb = 4'h0;
            for (int k = 0; k < 4; k++) begin
                if (wi * 4 + k < stored) begin
                    w.data[31 - 8 * k -: 8] = frame_q[wi * 4 + k];
                    w.strb[3 - k] = 1'b1;
                end
            end
`ifndef ETH_RX_BYTE_STRB_EN
            w.strb = 4'hF;
`endif
            exp_wr.push_back(w);
            a = a + 32'd4;
        end
        r.cnt = stored;
        r.ovf = (frame_q.size() > maxl);
        exp_res.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic push_byte(input u8 b, input bit last);
        int t = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        while (!bus.s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.s_ready) begin
            total++;
            bad++;
            $display("FAIL s_ready_timeout: got s_ready=0 after %0d cycles, expected 1", t);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] base, input int maxl);
        @(negedge clk);
        bus.cfg_base_addr = base;
        bus.cfg_max_len   = LEN_W'(maxl);
        bus.cfg_start     = 1'b1;
        @(negedge clk);
        bus.cfg_start     = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input int maxl, input int gap_max,
                              input bit mid_start, input bit lat_chk);
        int n;
        model_frame(base, maxl);
        start_frame(base, maxl);
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            if (mid_start && i == 3) begin
                bus.cfg_base_addr = 32'h40;
                bus.cfg_start     = 1'b1;
                @(negedge clk);
                bus.cfg_start     = 1'b0;
            end
            push_byte(frame_q[i], i == n - 1);
            if (lat_chk && i == 3) check("lat_valid", 96'(bus.mem_valid), 96'd1);
        end
        frame_q.delete();
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (exp_res.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_res.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_done_timeout: got no done after %0d cycles, expected done", nm, t);
            exp_res.delete();
            exp_wr.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Responder + scoreboard monitor.
    initial begin : monitor
        int wait_cnt = 0;
        bit cap = 0;
        bit hs = 0;
        bit prev_done = 0;
        logic [31:0] ca, cd;
        logic [3:0]  cs;
        wr_t  e;
        res_t r;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wait_cnt = 0; cap = 0; hs = 0; prev_done = 0;
                bus.mem_ready = 1'b0;
            end else begin
                if (hs) begin
                    bus.mem_ready = 1'b0;
                    hs = 0; cap = 0; wait_cnt = 0;
                    check("valid_drop", 96'(bus.mem_valid), 96'd0);
                end else if (bus.mem_valid) begin
                    bus.mem_ready = 1'b0;
                    if (!cap) begin
                        cap = 1;
                        ca = bus.mem_addr; cd = bus.mem_wdata; cs = bus.mem_wstrb;
                    end else begin
                        check("req_stable", 96'({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.s_ready}),
                              96'({ca, cd, cs, 1'b0}));
                    end
                    if (wait_cnt >= ready_delay) begin
                        bus.mem_ready = 1'b1;
                        hs = 1;
                        n_writes++;
                        if (exp_wr.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                                     bus.mem_addr, bus.mem_wdata);
                        end else begin
                            e = exp_wr.pop_front();
                            check("wr_addr", 96'(bus.mem_addr), 96'(e.addr));
                            check("wr_data", 96'(bus.mem_wdata), 96'(e.data));
                            check("wr_strb", 96'(bus.mem_wstrb), 96'(e.strb));
                            check("wr_instr", 96'(bus.mem_instr), 96'd0);
                        end
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                    cap = 0;
                    bus.mem_ready = ($urandom_range(0, 3) == 0);
                end
                if (bus.done) begin
                    check("done_single", 96'(prev_done), 96'd0);
                    if (exp_res.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done=1, expected 0");
                    end else begin
                        r = exp_res.pop_front();
                        check("byte_count", 96'(bus.byte_count), 96'(r.cnt));
                        check("overflow", 96'(bus.overflow), 96'(r.ovf));
                        check("writes_pending", 96'(exp_wr.size()), 96'd0);
                    end
                end
                prev_done = bus.done;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w0, t, n, maxl;
        logic [31:0] base;
        rst = 1'b1;
        bus.cfg_start = 1'b0; bus.cfg_base_addr = '0; bus.cfg_max_len = '0;
        bus.s_data = 8'd0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ctl", 96'({bus.mem_valid, bus.mem_instr, bus.s_ready, bus.done, bus.overflow}), 96'd0);
        check("rst_req", 96'({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}), 96'd0);
        check("rst_count", 96'(bus.byte_count), 96'd0);

        // 8 bytes, two full words, latency and held status.
        for (int i = 1; i <= 8; i++) frame_q.push_back(u8'(i));
        send_frame(32'h100, 64, 0, 0, 1);
        wait_done("t1");
        repeat (3) @(negedge clk);
        check("count_held", 96'({bus.byte_count, bus.overflow}), 96'({16'd8, 1'b0}));

        // 5 bytes, final partial word.
        for (int i = 0; i < 5; i++) frame_q.push_back(u8'(8'hA0 + i));
        send_frame(32'h200, 64, 1, 0, 0);
        wait_done("t2");

        // Overflow: 10 bytes into max 6, drained until s_last.
        for (int i = 0; i < 10; i++) frame_q.push_back(u8'(8'h10 + i));
        send_frame(32'h0, 6, 1, 0, 0);
        wait_done("t3");

        // Responder stalls ten cycles.
        ready_delay = 10;
        w0 = n_writes;
        for (int i = 0; i < 4; i++) frame_q.push_back(u8'($urandom));
        send_frame(32'h300, 64, 0, 0, 0);
        wait_done("t4");
        check("hold_writes", 96'(n_writes - w0), 96'd1);

        // Async reset while a write is pending.
        ready_delay = 1000;
        start_frame(32'h500, 64);
        for (int i = 0; i < 4; i++) push_byte(u8'(8'hC0 + i), i == 3);
        t = 0;
        while (!bus.mem_valid && t < 20) begin @(negedge clk); t++; end
        check("rst_pre_valid", 96'(bus.mem_valid), 96'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 96'({bus.mem_valid, bus.s_ready, bus.done}), 96'd0);
        check("rst_async_regs", 96'({bus.mem_addr, bus.byte_count}), 96'd0);
        @(negedge clk);
        rst = 1'b0;
        ready_delay = 2;
        @(negedge clk);
        for (int i = 0; i < 4; i++) frame_q.push_back(u8'(8'hD0 + i));
        send_frame(32'h400, 64, 0, 0, 0);
        wait_done("t5");

        // Address wrap plus an ignored mid-frame cfg_start.
        for (int i = 0; i < 8; i++) frame_q.push_back(u8'(8'h30 + i));
        send_frame(32'hFFFF_FFFC, 64, 0, 1, 0);
        wait_done("t6");

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            base = $urandom;
            if ($urandom_range(0, 4) == 0) base = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            maxl = $urandom_range(0, 24);
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) frame_q.push_back(u8'($urandom));
            ready_delay = $urandom_range(0, 4);
            send_frame(base, maxl, 2, 1'($urandom_range(0, 1)), 0);
            wait_done("rand");
        end

        check("final_queue", 96'(exp_wr.size() + exp_res.size()), 96'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/eth_rx_mem_writer.md
Name: eth_rx_mem_writer

Overview:
- Bus initiator on the PicoRV32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb).
- Takes a received Ethernet frame as a byte stream and writes it into the BRAM memory responder as 32-bit words.
- Starts at a configured base address and reports completion plus the stored byte count.
- Sits between the Ethernet RX path and the shared memory; the CPU arms it once per frame.

Parameters:
- LEN_W, 16, width of length configuration and byte counter.
- ADDR_W, 32, width of mem_addr and cfg_base_addr.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- cfg_start  in  1  one-cycle pulse arming capture of one frame.
- cfg_base_addr  in  ADDR_W  byte address of first word; bits [1:0] ignored and treated as 0.
- cfg_max_len  in  LEN_W  maximum bytes to store.
- s_data  in  8  received byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks final byte of frame.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- mem_valid  out  1  request valid.
- mem_instr  out  1  constant 0.
- mem_ready  in  1  responder completion.
- mem_addr  out  ADDR_W  word-aligned byte address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte strobes.
- mem_rdata  in  32  unused.
- done  out  1  one-cycle pulse when the frame is fully written.
- byte_count  out  LEN_W  bytes stored in the last frame; held until next cfg_start.
- overflow  out  1  frame exceeded cfg_max_len; held until next cfg_start.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address, lane index and word buffer cleared.
- Asynchronous reset mid-transaction drops mem_valid immediately. The frame is abandoned.
- States: IDLE, COLLECT, WRITE, GAP, DONE.
- IDLE:
  - s_ready=0.
  - cfg_start latches base/len, clears byte_count/overflow and goes to COLLECT.
  - cfg_start is ignored in all other states.
- COLLECT:
  - s_ready=1.
  - Bytes are big-endian packed. Lane 0 goes to wdata[31:24] (address+0); lane 3 goes to wdata[7:0] (address+3).
  - Each accepted byte increments byte_count, unless byte_count==cfg_max_len. In that case the byte is dropped and overflow is set.
  - Go to WRITE when lane 3 is filled, or when s_last is accepted with at least one stored byte in the buffer.
  - If s_last is accepted and the buffer is empty (all bytes dropped), go directly to DONE.
- WRITE:
  - s_ready=0.
  - mem_valid=1, mem_addr=current word address, mem_wdata=buffer, mem_wstrb=4'hF (see optional feature for partial words).
  - Unfilled lanes are zero.
  - All request outputs are stable while mem_valid=1.
  - On a mem_ready sample: mem_valid goes 0 next cycle, word address += 4 (wraps modulo 2^ADDR_W), go to GAP.
- GAP:
  - One cycle with mem_valid=0. This is required so the responder's valid tracker returns to idle.
  - Then go to DONE if the written word held the s_last byte, else to COLLECT.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - The fourth byte of a word accepted at edge N gives mem_valid=1 from N+1.
  - With the 2-cycle responder, mem_ready is seen at N+3, and COLLECT resumes at N+5.
- s_last on the fourth lane: a single WRITE, then DONE.
- mem_ready while mem_valid=0 is ignored.

Optional Feature:
- Macro: ETH_RX_BYTE_STRB_EN.
- Defined: a final partial word uses exact strobes for the filled lanes only: 1 byte→4'h8, 2→4'hC, 3→4'hE. Memory bytes beyond the frame end are untouched.
- Undefined: the final partial word is written with 4'hF and zero padding. This is the default, because the BRAM responder supports only a whole-word write enable.

Test Plan:
- Base 0x100, max 64, frame of 8 bytes 0x01..0x08 → two writes: addr 0x100 data 0x01020304, addr 0x104 data 0x05060708, both wstrb F. Then done pulse, byte_count=8, overflow=0.
- Base 0x200, max 64, frame of 5 bytes 0xA0..0xA4 → 0x200=0xA0A1A2A3, 0x204=0xA4000000. wstrb F, or 8 with ETH_RX_BYTE_STRB_EN; byte_count=5.
- Base 0x0, max 6, frame of 10 bytes → writes 0x0 and 0x4 only (second word 2 bytes, zero-padded); byte_count=6, overflow=1; s_ready keeps draining until s_last.
- Responder holds mem_ready low for 10 cycles → mem_valid and request fields stay constant, s_ready=0 throughout; exactly one write is recorded.
- Assert rst while mem_valid=1 → mem_valid=0 in the same cycle, state IDLE. A later cfg_start with a 4-byte frame writes normally.
- Base 0xFFFFFFFC, frame of 8 bytes → second write is at address 0x00000000 (wrap); cfg_start pulsed mid-frame is ignored.
